// File: rtl/pdu_ring_ctrl.sv
// Ring-buffer pointer manager for the PDU-to-PCIe path: owns the tail, tracks the
// host head, produces registered almost-full back-pressure and coalesced doorbells.
module pdu_ring_ctrl #(
    parameter int PDU_AWIDTH    = 12,
    parameter int MAX_PDU_FLITS = 64,
    parameter int DB_THRESH     = 32,
    parameter int DB_TIMEOUT    = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pcie_rb_update_valid,
    input  logic [PDU_AWIDTH-1:0] pcie_rb_update_size,
    output logic [PDU_AWIDTH-1:0] pcie_rb_wr_base_addr,
    output logic                  pcie_rb_almost_full,
    input  logic                  ring_enable,
    input  logic                  ring_clear,
    input  logic                  host_head_valid,
    input  logic [PDU_AWIDTH-1:0] host_head_data,
    output logic                  doorbell_valid,
    input  logic                  doorbell_ready,
    output logic [PDU_AWIDTH-1:0] doorbell_tail,
    output logic [PDU_AWIDTH:0]   ring_used,
    output logic                  ring_err
);

    localparam int AW = PDU_AWIDTH;
    localparam int PW = PDU_AWIDTH + 1;
    localparam int TW = $clog2(DB_TIMEOUT + 1);

    localparam logic [PW-1:0] RING_CAP  = PW'((2 ** AW) - 1);
    localparam logic [PW-1:0] AF_MARGIN = PW'(MAX_PDU_FLITS);
    localparam logic [PW-1:0] THRESH    = PW'(DB_THRESH);
    localparam logic [PW-1:0] PEND_MAX  = '1;
    localparam logic [TW-1:0] TIMEOUT   = TW'(DB_TIMEOUT);

    logic [AW-1:0] tail_q, tail_d;
    logic [AW-1:0] head_q, head_d;
    logic [PW-1:0] pending_q, pending_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          db_valid_q, db_valid_d;
    logic          err_q, err_d;
    logic          almost_full_q, almost_full_d;

    logic [AW-1:0] used_cur;
    logic [PW-1:0] free_cur;
    logic [AW-1:0] head_dist;
    logic [PW:0]   pend_sum;
    logic [AW-1:0] used_next;
    logic [PW-1:0] free_next;

    // Doorbell handshake: doorbell_valid, once raised, stays high and doorbell_tail
    // follows the live tail until a cycle with doorbell_ready high accepts it.
    always_comb begin
        used_cur  = tail_q - head_q;
        free_cur  = RING_CAP - {1'b0, used_cur};
        head_dist = host_head_data - head_q;
        pend_sum  = {1'b0, pending_q} + {2'b00, pcie_rb_update_size};

        tail_d     = tail_q;
        head_d     = head_q;
        pending_d  = pending_q;
        timer_d    = timer_q;
        db_valid_d = db_valid_q;
        err_d      = err_q;

        // The tail always advances: the flits are already in host memory.
        if (pcie_rb_update_valid) begin
            tail_d    = tail_q + pcie_rb_update_size;
            pending_d = pend_sum[PW] ? PEND_MAX : pend_sum[PW-1:0];
            timer_d   = '0;
            if ({1'b0, pcie_rb_update_size} > free_cur) begin
                err_d = 1'b1;
            end
        end else if (pending_q != '0 && timer_q < TIMEOUT) begin
            timer_d = timer_q + TW'(1);
        end

        // A head that moves past the tail is refused; the check uses pre-update occupancy.
        if (host_head_valid) begin
            if (head_dist <= used_cur) begin
                head_d = host_head_data;
            end else begin
                err_d = 1'b1;
            end
        end

        if (db_valid_q) begin
            if (doorbell_ready) begin
                db_valid_d = 1'b0;
                pending_d  = pcie_rb_update_valid ? {1'b0, pcie_rb_update_size} : '0;
                timer_d    = '0;
            end
        end else begin
            db_valid_d = (pending_q >= THRESH) ||
                         (pending_q != '0 && timer_q >= TIMEOUT);
        end

        if (ring_clear) begin
            tail_d     = '0;
            head_d     = '0;
            pending_d  = '0;
            timer_d    = '0;
            db_valid_d = 1'b0;
            err_d      = 1'b0;
        end

        used_next     = tail_d - head_d;
        free_next     = RING_CAP - {1'b0, used_next};
        almost_full_d = !ring_enable || (free_next < AF_MARGIN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tail_q        <= '0;
            head_q        <= '0;
            pending_q     <= '0;
            timer_q       <= '0;
            db_valid_q    <= 1'b0;
            err_q         <= 1'b0;
            almost_full_q <= 1'b1;
        end else begin
            tail_q        <= tail_d;
            head_q        <= head_d;
            pending_q     <= pending_d;
            timer_q       <= timer_d;
            db_valid_q    <= db_valid_d;
            err_q         <= err_d;
            almost_full_q <= almost_full_d;
        end
    end

    assign pcie_rb_wr_base_addr = tail_q;
    assign doorbell_tail        = tail_q;
    assign pcie_rb_almost_full  = almost_full_q;
    assign doorbell_valid       = db_valid_q;
    assign ring_used            = {1'b0, used_cur};
    assign ring_err             = err_q;

endmodule

// File: doc/pdu_ring_ctrl.md
# pdu_ring_ctrl

PCIe ring-buffer pointer manager directly downstream of the PDU generator. Owns the ring tail pointer, which it exports as the PDU generator's write base address, and tracks the host-written head pointer. Produces a registered almost-full back-pressure signal and raises coalesced doorbells that tell the host how far the tail has advanced. All PDUs written by the generator are committed here through one update pulse per PDU.

## Interface
Parameters:
- PDU_AWIDTH, 12: ring address width; ring depth N = 2^PDU_AWIDTH flits.
- MAX_PDU_FLITS, 64: worst-case flits per PDU (header, packet, rule and eop flits); used as the almost-full margin.
- DB_THRESH, 32: pending-flit count that forces a doorbell.
- DB_TIMEOUT, 256: idle cycles after which any pending flits force a doorbell.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  sole clock.
- rst_n  in  1  synchronous active-low reset.
- pcie_rb_update_valid  in  1  one-cycle pulse: a PDU has been committed to the ring.
- pcie_rb_update_size  in  PDU_AWIDTH  flits in the committed PDU; sampled only with valid.
- pcie_rb_wr_base_addr  out  PDU_AWIDTH  current tail; the first (header) address of the next PDU.
- pcie_rb_almost_full  out  1  registered back-pressure to the PDU generator.
- ring_enable  in  1  host enable level; 0 forces almost_full.
- ring_clear  in  1  one-cycle pulse: zero tail, head and doorbell state.
- host_head_valid  in  1  host head-pointer write strobe.
- host_head_data  in  PDU_AWIDTH  new head value.
- doorbell_valid  out  1  doorbell request, held until accepted.
- doorbell_ready  in  1  doorbell accept.
- doorbell_tail  out  PDU_AWIDTH  equals the tail register at all times.
- ring_used  out  PDU_AWIDTH+1  occupancy, (tail − head) mod N.
- ring_err  out  1  sticky error flag; cleared only by reset or ring_clear.

## Operation
- State: tail, head, pending (PDU_AWIDTH+1 bits, saturating), idle timer, doorbell_valid, ring_err.
- Free space: N − 1 − used. The ring holds at most N − 1 flits.
- Update: tail_next = tail + size, mod N. The tail always advances because the data is already written.
  - If size > free, set ring_err.
  - pending_next = min(pending + size, 2^(PDU_AWIDTH+1) − 1).
- Head write: valid only if (host_head_data − head) mod N ≤ used, evaluated against the current-cycle used.
  - Valid write: head_next = host_head_data.
  - Invalid write (head passes tail): ignore the write and set ring_err.
- Simultaneous update and head write: apply both. The head check uses the pre-update used value.
- ring_clear: tail, head, pending and timer go to 0; doorbell_valid and ring_err go to 0. Clear wins over a same-cycle update or head write; those are dropped and raise no error.
- almost_full (registered) = !ring_enable | (free_next < MAX_PDU_FLITS), where free_next is computed from tail_next and head_next.
- Doorbell:
  - Assert doorbell_valid when pending ≥ DB_THRESH, or when pending > 0 and the timer reaches DB_TIMEOUT.
  - Once asserted, doorbell_valid holds until doorbell_ready.
  - On accept: pending <= size of any same-cycle update, otherwise 0; timer <= 0.
- Idle timer: increments while pending > 0 and no update arrives; resets to 0 on any update; saturates at DB_TIMEOUT.

## Timing
- Reset (rst_n = 0 at a clk edge):
  - tail, head, pending, timer, ring_used = 0.
  - pcie_rb_wr_base_addr = 0.
  - pcie_rb_almost_full = 1.
  - doorbell_valid = 0, ring_err = 0.
- Reset mid-PDU discards all state. The upstream generator must be reset in the same cycle.
- Update pulse in cycle t: wr_base_addr, ring_used and almost_full reflect it in cycle t+1. This gives zero added latency, so the generator's next START check already sees the new free space.
- Head write in cycle t: visible on almost_full and ring_used in cycle t+1.
- Doorbell: doorbell_valid rises in the cycle after the triggering condition is registered. doorbell_tail tracks the live tail while doorbell_valid is held.
- Wrap-around: all pointer arithmetic is modulo N. A PDU may straddle address N−1 → 0.
- ring_enable 0→1 with adequate free space: almost_full drops one cycle later.

## Test plan
Parameters for all scenarios: PDU_AWIDTH=4 (N=16), MAX_PDU_FLITS=4, DB_THRESH=8, DB_TIMEOUT=5.
- Reset then ring_enable=1 → almost_full 1 during reset, 0 one cycle after enable; wr_base_addr=0; ring_used=0.
- Updates of size 5 then 4 → wr_base_addr 5 then 9; ring_used 9; doorbell_valid rises (pending 9 ≥ 8); with ready=1, pending returns to 0.
- Update of size 3, then idle → doorbell_valid rises after 5 idle cycles with doorbell_tail=3.
- tail=9, head=0 (free 6), update size 3 → free 3 < 4, almost_full=1 next cycle; then head write 8 → free 11, almost_full=0 next cycle.
- tail=14, head=10, update size 4 → wr_base_addr=2 (wrap), ring_used=8; then head write 15 → accepted; then head write 5 (passes tail) → ignored, ring_err=1.
- Same-cycle update(size 2) and ring_clear → tail=0, head=0, ring_err=0, doorbell_valid=0; a subsequent update(size 6) → wr_base_addr=6.
